// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encoding, opcodes and datapath select codes shared by the
// multicycle controller and its helpers.
package ctrl_pkg;
    typedef enum logic [4:0] {
        RST      = 5'd0,
        FETCH    = 5'd1,
        WAIT_I   = 5'd2,
        IR_LOAD  = 5'd3,
        DECODE   = 5'd4,
        MEM_ADDR = 5'd5,
        MEM_RD   = 5'd6,
        WAIT_D   = 5'd7,
        MDR_LOAD = 5'd8,
        LW_WB    = 5'd9,
        SW_WR    = 5'd10,
        R_EXEC   = 5'd11,
        R_WB     = 5'd12,
        I_EXEC   = 5'd13,
        I_WB     = 5'd14,
        BRANCH   = 5'd15,
        JUMP     = 5'd16,
        TRAP     = 5'd17
    } estado_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] ULA_ADD   = 2'b00;
    localparam logic [1:0] ULA_SUB   = 2'b01;
    localparam logic [1:0] ULA_FUNCT = 2'b10;
    localparam logic [1:0] ULA_IDLE  = 2'b11;

    localparam logic [1:0] FB_B       = 2'b00;
    localparam logic [1:0] FB_4       = 2'b01;
    localparam logic [1:0] FB_IMM     = 2'b10;
    localparam logic [1:0] FB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PC_ULA   = 2'b00;
    localparam logic [1:0] PC_SAIDA = 2'b01;
    localparam logic [1:0] PC_JUMP  = 2'b10;

    function automatic estado_t decodifica(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:   return MEM_ADDR;
            OP_R:           return R_EXEC;
            OP_ADDI:        return I_EXEC;
            OP_BEQ, OP_BNE: return BRANCH;
            OP_J:           return JUMP;
            default:        return TRAP;
        endcase
    endfunction
endpackage

// File: rtl/contador_espera.sv
// contador_espera: memory wait counter; loaded on entry to a wait state,
// done flags the last wait cycle.
module contador_espera #(
    parameter int W = 2
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] valor,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) cnt <= '0;
        else if (load) cnt <= valor;
        else if (dec) cnt <= cnt - W'(1);
    end

    // <= rather than == keeps a stray zero count from wrapping forever
    assign done = cnt <= W'(1);
endmodule

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: Moore control unit of a multicycle MIPS subset with
// configurable memory wait states.
module controle_multiciclo
    import ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [5:0] OpCode,
    input  logic       Zero,
    output logic       PCEsc,
    output logic       IREsc,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemParaReg,
    output logic       IouD,
    output logic       CtrMem,
    output logic       ULAFonteA,
    output logic       RegACtrl,
    output logic       RegBCtrl,
    output logic       ULASaidaCtrl,
    output logic       MDRCtrl,
    output logic [1:0] ULAFonteB,
    output logic [1:0] ULAOp,
    output logic [1:0] PCFonte,
    output logic       Excecao,
    output logic [4:0] State
);
    localparam int W = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

    estado_t estado, proximo;
    logic    cnt_done;

    contador_espera #(.W(W)) u_espera (
        .Clock (Clock),
        .Reset (Reset),
        .load  (estado == FETCH || estado == MEM_RD),
        .dec   (estado == WAIT_I || estado == WAIT_D),
        .valor (W'(MEM_LAT)),
        .done  (cnt_done)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) estado <= RST;
        else estado <= proximo;
    end

    assign State = estado;

    always_comb begin
        PCEsc        = 1'b0;
        IREsc        = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        MemParaReg   = 1'b0;
        IouD         = 1'b0;
        CtrMem       = 1'b0;
        ULAFonteA    = 1'b0;
        RegACtrl     = 1'b0;
        RegBCtrl     = 1'b0;
        ULASaidaCtrl = 1'b0;
        MDRCtrl      = 1'b0;
        ULAFonteB    = FB_B;
        ULAOp        = ULA_IDLE;
        PCFonte      = PC_ULA;
        Excecao      = 1'b0;
        proximo      = FETCH;
        case (estado)
            RST: proximo = FETCH;
            FETCH: begin
                ULAFonteB = FB_4;
                ULAOp     = ULA_ADD;
                PCEsc     = 1'b1;
                proximo   = (MEM_LAT == 0) ? IR_LOAD : WAIT_I;
            end
            WAIT_I: proximo = cnt_done ? IR_LOAD : WAIT_I;
            IR_LOAD: begin
                IREsc   = 1'b1;
                proximo = DECODE;
            end
            DECODE: begin
                RegACtrl     = 1'b1;
                RegBCtrl     = 1'b1;
                ULAFonteB    = FB_IMM_SL2;
                ULAOp        = ULA_ADD;
                ULASaidaCtrl = 1'b1;
                proximo      = decodifica(OpCode);
            end
            MEM_ADDR: begin
                ULAFonteA    = 1'b1;
                ULAFonteB    = FB_IMM;
                ULAOp        = ULA_ADD;
                ULASaidaCtrl = 1'b1;
                proximo      = (OpCode == OP_SW) ? SW_WR : MEM_RD;
            end
            MEM_RD: begin
                IouD    = 1'b1;
                proximo = (MEM_LAT == 0) ? MDR_LOAD : WAIT_D;
            end
            WAIT_D: begin
                IouD    = 1'b1;
                proximo = cnt_done ? MDR_LOAD : WAIT_D;
            end
            MDR_LOAD: begin
                MDRCtrl = 1'b1;
                proximo = LW_WB;
            end
            LW_WB: begin
                RegWrite   = 1'b1;
                MemParaReg = 1'b1;
            end
            SW_WR: begin
                CtrMem = 1'b1;
                IouD   = 1'b1;
            end
            R_EXEC: begin
                ULAFonteA    = 1'b1;
                ULAOp        = ULA_FUNCT;
                ULASaidaCtrl = 1'b1;
                proximo      = R_WB;
            end
            R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            I_EXEC: begin
                ULAFonteA    = 1'b1;
                ULAFonteB    = FB_IMM;
                ULAOp        = ULA_ADD;
                ULASaidaCtrl = 1'b1;
                proximo      = I_WB;
            end
            I_WB: RegWrite = 1'b1;
            BRANCH: begin
                ULAFonteA = 1'b1;
                ULAOp     = ULA_SUB;
                PCFonte   = PC_SAIDA;
                PCEsc     = (OpCode == OP_BEQ && Zero) || (OpCode == OP_BNE && !Zero);
            end
            JUMP: begin
                PCEsc   = 1'b1;
                PCFonte = PC_JUMP;
            end
            TRAP: Excecao = 1'b1;
            default: proximo = FETCH;
        endcase
    end
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: random instruction streams on three latencies,
// compared cycle by cycle against a state-trace reference model.
module tb_controle_multiciclo;
    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [5:0]  OpCode = 6'b0;
    logic        Zero = 1'b0;
    logic [23:0] obs [3];
    int          vectors = 0;
    int          miscompares = 0;
    int          exp_q [$];

    always #5 Clock = ~Clock;

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : (g == 1) ? 2 : 5;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        logic [23:0] o;
        controle_multiciclo #(.MEM_LAT(lat_of(g))) dut (
            .Clock        (Clock),
            .Reset        (Reset),
            .OpCode       (OpCode),
            .Zero         (Zero),
            .PCEsc        (o[0]),
            .IREsc        (o[1]),
            .RegWrite     (o[2]),
            .RegDst       (o[3]),
            .MemParaReg   (o[4]),
            .IouD         (o[5]),
            .CtrMem       (o[6]),
            .ULAFonteA    (o[7]),
            .RegACtrl     (o[8]),
            .RegBCtrl     (o[9]),
            .ULASaidaCtrl (o[10]),
            .MDRCtrl      (o[11]),
            .ULAFonteB    (o[13:12]),
            .ULAOp        (o[15:14]),
            .PCFonte      (o[17:16]),
            .Excecao      (o[18]),
            .State        (o[23:19])
        );
        assign obs[g] = o;
    end

    // expected strobes per state, straight from the per-state output table
    function automatic logic [18:0] exp_out(input int st, input logic [5:0] op, input logic z);
        logic pcesc = 0, iresc = 0, rw = 0, rdst = 0, mreg = 0, iord = 0, ctrm = 0, fa = 0;
        logic rega = 0, regb = 0, saida = 0, mdr = 0, exc = 0;
        logic [1:0] fb = 2'b00, uop = 2'b11, pcf = 2'b00;
        case (st)
            1:  begin fb = 2'b01; uop = 2'b00; pcesc = 1; end
            3:  iresc = 1;
            4:  begin rega = 1; regb = 1; fb = 2'b11; uop = 2'b00; saida = 1; end
            5:  begin fa = 1; fb = 2'b10; uop = 2'b00; saida = 1; end
            6, 7: iord = 1;
            8:  mdr = 1;
            9:  begin rw = 1; mreg = 1; end
            10: begin ctrm = 1; iord = 1; end
            11: begin fa = 1; uop = 2'b10; saida = 1; end
            12: begin rw = 1; rdst = 1; end
            13: begin fa = 1; fb = 2'b10; uop = 2'b00; saida = 1; end
            14: rw = 1;
            15: begin fa = 1; uop = 2'b01; pcf = 2'b01; pcesc = (op == 6'b000100) ? z : ~z; end
            16: begin pcesc = 1; pcf = 2'b10; end
            17: exc = 1;
            default: ;
        endcase
        return {exc, pcf, uop, fb, mdr, saida, regb, rega, fa, ctrm, iord, mreg, rdst, rw, iresc, pcesc};
    endfunction

    // whole instruction as a list of visited states, FETCH through last state
    task automatic build_trace(input int lat, input logic [5:0] op);
        exp_q = {1};
        repeat (lat) exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(4);
        case (op)
            6'b100011: begin
                exp_q.push_back(5);
                exp_q.push_back(6);
                repeat (lat) exp_q.push_back(7);
                exp_q.push_back(8);
                exp_q.push_back(9);
            end
            6'b101011: begin exp_q.push_back(5); exp_q.push_back(10); end
            6'b000000: begin exp_q.push_back(11); exp_q.push_back(12); end
            6'b001000: begin exp_q.push_back(13); exp_q.push_back(14); end
            6'b000100, 6'b000101: exp_q.push_back(15);
            6'b000010: exp_q.push_back(16);
            default: exp_q.push_back(17);
        endcase
    endtask

    task automatic check(input int g, input int st, input logic [5:0] op, input logic z, input string tag);
        logic [23:0] e;
        e = {st[4:0], exp_out(st, op, z)};
        vectors++;
        assert (obs[g] === e) else begin
            miscompares++;
            $error("FAIL %s lat=%0d op=%b state=%0d: observed %h expected %h", tag, lat_of(g), op, st, obs[g], e);
        end
    endtask

    task automatic run_instr(input int g, input logic [5:0] op, input int zmode);
        OpCode = op;
        build_trace(lat_of(g), op);
        foreach (exp_q[i]) begin
            @(negedge Clock);
            Zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
            #1 check(g, exp_q[i], op, Zero, "instr");
        end
    endtask

    task automatic reset_in_wait(input int g);
        OpCode = 6'b100011;
        build_trace(lat_of(g), OpCode);
        foreach (exp_q[i]) begin
            @(negedge Clock);
            #1 check(g, exp_q[i], OpCode, Zero, "lw_pre_reset");
            if (exp_q[i] == 7) break;
        end
        Reset = 1'b1;
        #1 check(g, 0, OpCode, Zero, "reset_async");
        @(negedge Clock);
        #1 check(g, 0, OpCode, Zero, "reset_held");
        Reset = 1'b0;
        run_instr(g, 6'b100011, -1);
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000101, 6'b000010};
        int k = $urandom_range(0, 7);
        return (k == 7) ? 6'($urandom) : ops[k];
    endfunction

    initial begin
        for (int g = 0; g < 3; g++) begin
            @(negedge Clock);
            #1 Reset = 1'b1;
            #1 check(g, 0, OpCode, Zero, "reset");
            @(negedge Clock);
            #1 Reset = 1'b0;
            run_instr(g, 6'b100011, -1);
            run_instr(g, 6'b101011, -1);
            run_instr(g, 6'b000000, -1);
            run_instr(g, 6'b000100, 1);
            run_instr(g, 6'b000101, 1);
            run_instr(g, 6'b000100, 0);
            run_instr(g, 6'b111111, -1);
            repeat (40) run_instr(g, rand_op(), -1);
            if (g > 0) reset_in_wait(g);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/controle_multiciclo.md
CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 Parameter MEM_LAT, default 2, memory wait cycles after each memory access, legal 0..15.
REQ-002 Clock  input  1  single clock; all state changes on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 OpCode  input  6  instruction bits [31:26] from IR.
REQ-005 Zero  input  1  ALU zero flag, valid in BRANCH state.
REQ-006 PCEsc, IREsc, RegWrite, RegDst, MemParaReg, IouD, CtrMem, ULAFonteA  output  1 each  standard datapath strobes/selects (CtrMem 1 = write).
REQ-007 RegACtrl, RegBCtrl, ULASaidaCtrl, MDRCtrl  output  1 each  A, B, ALUOut and MDR register load enables.
REQ-008 ULAFonteB  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-009 ULAOp  output  2  00 add, 01 sub, 10 funct-decoded, 11 idle.
REQ-010 PCFonte  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 Excecao  output  1  one-cycle pulse on unsupported opcode.
REQ-012 State  output  5  current state encoding per REQ-016.

Function
REQ-013 Outputs SHALL be Moore-decoded from State, except PCEsc in BRANCH (REQ-024).
REQ-014 Any output not listed for a state SHALL be 0; ULAOp SHALL be 11 unless listed.
REQ-015 Supported opcodes: 000000 R-type, 100011 lw, 101011 sw, 001000 addi, 000100 beq, 000101 bne, 000010 j.
REQ-016 Encodings: RST0 FETCH1 WAIT_I2 IR_LOAD3 DECODE4 MEM_ADDR5 MEM_RD6 WAIT_D7 MDR_LOAD8 LW_WB9 SW_WR10 R_EXEC11 R_WB12 I_EXEC13 I_WB14 BRANCH15 JUMP16 TRAP17.
REQ-017 RST: all outputs 0, ULAOp 11; next FETCH.
REQ-018 FETCH: IouD 0, ULAFonteA 0, ULAFonteB 01, ULAOp 00, PCFonte 00, PCEsc 1; next WAIT_I, or IR_LOAD if MEM_LAT=0.
REQ-019 WAIT_I/WAIT_D: wait counter loaded with MEM_LAT on entry; remain exactly MEM_LAT cycles; IouD held at 0 in WAIT_I, 1 in WAIT_D.
REQ-020 IR_LOAD: IREsc 1; next DECODE.
REQ-021 DECODE: RegACtrl 1, RegBCtrl 1, ULAFonteA 0, ULAFonteB 11, ULAOp 00, ULASaidaCtrl 1; next by OpCode: lw/sw MEM_ADDR, R-type R_EXEC, addi I_EXEC, beq/bne BRANCH, j JUMP, other TRAP.
REQ-022 MEM_ADDR: ULAFonteA 1, ULAFonteB 10, ULAOp 00, ULASaidaCtrl 1; next MEM_RD (lw) or SW_WR (sw).
REQ-023 MEM_RD: IouD 1; next WAIT_D, or MDR_LOAD if MEM_LAT=0; MDR_LOAD: MDRCtrl 1; LW_WB: RegWrite 1, MemParaReg 1, RegDst 0; SW_WR: CtrMem 1, IouD 1; both next FETCH.
REQ-024 BRANCH: ULAFonteA 1, ULAFonteB 00, ULAOp 01, PCFonte 01; PCEsc = Zero for beq, ~Zero for bne (OpCode sampled combinationally); next FETCH.
REQ-025 R_EXEC: ULAFonteA 1, ULAFonteB 00, ULAOp 10, ULASaidaCtrl 1; R_WB: RegWrite 1, RegDst 1; next FETCH.
REQ-026 I_EXEC: ULAFonteA 1, ULAFonteB 10, ULAOp 00, ULASaidaCtrl 1; I_WB: RegWrite 1, RegDst 0; next FETCH.
REQ-027 JUMP: PCEsc 1, PCFonte 10; next FETCH. TRAP: Excecao 1; next FETCH (PC already advanced).
REQ-028 Latency with L=MEM_LAT: lw 2L+7, sw/R/addi L+5, beq/bne/j L+4 cycles, RST excluded.
REQ-029 Unreachable encodings 18..31 SHALL transition to FETCH with outputs as RST.

Reset
REQ-030 Reset assertion SHALL force State=RST and all outputs to RST values immediately, independent of Clock, including mid-wait or mid-instruction.
REQ-031 Reset SHALL clear the wait counter; first state after deassertion edge is FETCH.

Structure
REQ-032 Shared package ctrl_pkg SHALL hold state enum, opcode constants, ULAOp/ULAFonteB/PCFonte codes.
REQ-033 Wait counter SHALL be sub-module contador_espera (load, decrement, done flag), width sized from MEM_LAT.

Verification
REQ-034 Reset asserted during WAIT_D of lw -> State=0 and all strobes 0 same cycle; FETCH one cycle after deassertion.
REQ-035 MEM_LAT=2, lw -> 11 cycles FETCH-to-FETCH, MDRCtrl exactly one cycle, RegWrite+MemParaReg in cycle 11.
REQ-036 MEM_LAT=0, sw -> states 1,3,4,5,10,1; CtrMem=1 only in SW_WR.
REQ-037 beq with Zero=1 -> PCEsc=1, PCFonte=01 in BRANCH; bne with Zero=1 -> PCEsc=0.
REQ-038 OpCode 111111 -> TRAP, Excecao pulse width 1, next state FETCH, RegWrite never 1.
REQ-039 MEM_LAT=5, R-type -> WAIT_I held 5 cycles, RegWrite+RegDst=1 in R_WB, total 10 cycles.
